// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared single-precision constants, operand classes and the unpacked entry type
package fp_pkg;

    localparam logic [1:0] ROUND_TO_NEAREST = 2'b00;
    localparam logic [1:0] ROUND_TO_ZERO    = 2'b01;
    localparam logic [1:0] ROUND_TO_POS_INF = 2'b10;
    localparam logic [1:0] ROUND_TO_NEG_INF = 2'b11;

    localparam logic [31:0] FP_QNAN     = 32'h7FC00000;
    localparam int          FP_EXP_BIAS = 127;
    localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;

    typedef enum logic [2:0] {
        ZERO,
        SUB,
        NORM,
        INF,
        NAN
    } fp_class_e;

    // One unpacked operand pair as presented to the multiplier.
    typedef struct packed {
        logic        sign_num1;
        logic        sign_num2;
        logic [7:0]  exp_num1;
        logic [7:0]  exp_num2;
        logic [22:0] mantissa_num1;
        logic [22:0] mantissa_num2;
        logic        normilized_bit_num1;
        logic        normilized_bit_num2;
        logic [1:0]  rounding_mode;
        logic        special_valid;
        logic [31:0] special_result;
    } fp_entry_t;

endpackage

// File: rtl/fp_operand_classify.sv
// rtl/fp_operand_classify.sv - combinational unpack and classification of one packed single-precision word
module fp_operand_classify
    import fp_pkg::*;
(
    input  logic [31:0] word,
    output fp_class_e   cls,
    output logic        sign,
    output logic [7:0]  exp,
    output logic [22:0] frac,
    output logic        hidden
);

    always_comb begin
        sign = word[31];
        exp  = word[30:23];
        frac = word[22:0];
        if (exp == 8'h00) begin
            cls = (frac == 23'h0) ? ZERO : SUB;
        end else if (exp == FP_EXP_MAX) begin
            cls = (frac == 23'h0) ? INF : NAN;
        end else begin
            cls = NORM;
        end
        hidden = (cls == NORM);
    end

endmodule

// File: rtl/fp_mul_operand_stage.sv
// rtl/fp_mul_operand_stage.sv - operand unpack, special-case bypass and two-entry skid buffer ahead of the multiplier
module fp_mul_operand_stage
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [1:0]  in_rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sign_num1,
    output logic        sign_num2,
    output logic [7:0]  exp_num1,
    output logic [7:0]  exp_num2,
    output logic [22:0] mantissa_num1,
    output logic [22:0] mantissa_num2,
    output logic        normilized_bit_num1,
    output logic        normilized_bit_num2,
    output logic [1:0]  rounding_mode,
    output logic        special_valid,
    output logic [31:0] special_result
);

    // Biased exponent sum bounds: below 127 the product underflows, and
    // at 127+255 or more it overflows past the largest finite exponent.
    localparam logic [8:0] EXP_SUM_UFLOW = 9'(FP_EXP_BIAS - 1);
    localparam logic [8:0] EXP_SUM_OFLOW = 9'(FP_EXP_BIAS + 255);

    fp_class_e   cls_a, cls_b;
    logic        sign_a, sign_b, hid_a, hid_b;
    logic [7:0]  exp_a, exp_b;
    logic [22:0] frac_a, frac_b;

    fp_operand_classify u_cls_a (
        .word   (in_a),
        .cls    (cls_a),
        .sign   (sign_a),
        .exp    (exp_a),
        .frac   (frac_a),
        .hidden (hid_a)
    );

    fp_operand_classify u_cls_b (
        .word   (in_b),
        .cls    (cls_b),
        .sign   (sign_b),
        .exp    (exp_b),
        .frac   (frac_b),
        .hidden (hid_b)
    );

    logic        a_zero, b_zero, a_inf, b_inf, res_sign;
    logic [8:0]  exp_sum;
    logic        spec_valid_c;
    logic [31:0] spec_result_c;

    always_comb begin
        // Subnormals are flushed, so they resolve exactly like zeros.
        a_zero        = (cls_a == ZERO) || (cls_a == SUB);
        b_zero        = (cls_b == ZERO) || (cls_b == SUB);
        a_inf         = (cls_a == INF);
        b_inf         = (cls_b == INF);
        res_sign      = sign_a ^ sign_b;
        exp_sum       = {1'b0, exp_a} + {1'b0, exp_b};
        spec_valid_c  = 1'b1;
        spec_result_c = '0;
        if ((cls_a == NAN) || (cls_b == NAN) || (a_inf && b_zero) || (a_zero && b_inf)) begin
            spec_result_c = FP_QNAN;
        end else if (a_inf || b_inf) begin
            spec_result_c = {res_sign, FP_EXP_MAX, 23'h0};
        end else if (a_zero || b_zero) begin
            spec_result_c = {res_sign, 31'h0};
        end else if (exp_sum <= EXP_SUM_UFLOW) begin
            spec_result_c = {res_sign, 31'h0};
        end else if (exp_sum >= EXP_SUM_OFLOW) begin
            spec_result_c = {res_sign, FP_EXP_MAX, 23'h0};
        end else begin
            spec_valid_c  = 1'b0;
        end
    end

    fp_entry_t new_entry;

    always_comb begin
        new_entry.sign_num1           = sign_a;
        new_entry.sign_num2           = sign_b;
        new_entry.exp_num1            = exp_a;
        new_entry.exp_num2            = exp_b;
        new_entry.mantissa_num1       = frac_a;
        new_entry.mantissa_num2       = frac_b;
        new_entry.normilized_bit_num1 = hid_a;
        new_entry.normilized_bit_num2 = hid_b;
        new_entry.rounding_mode       = in_rm;
        new_entry.special_valid       = spec_valid_c;
        new_entry.special_result      = spec_result_c;
    end

    fp_entry_t main_q, main_d, skid_q, skid_d;
    logic      main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic      accept, drain;

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & ~skid_valid_q;
    assign drain    = main_valid_q & out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (skid_valid_q) begin
            // No accept is possible while the skid is full; refill main from skid.
            if (drain) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q || drain) begin
                main_d       = new_entry;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = new_entry;
                skid_valid_d = 1'b1;
            end
        end else if (drain) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid           = main_valid_q;
    assign sign_num1           = main_q.sign_num1;
    assign sign_num2           = main_q.sign_num2;
    assign exp_num1            = main_q.exp_num1;
    assign exp_num2            = main_q.exp_num2;
    assign mantissa_num1       = main_q.mantissa_num1;
    assign mantissa_num2       = main_q.mantissa_num2;
    assign normilized_bit_num1 = main_q.normilized_bit_num1;
    assign normilized_bit_num2 = main_q.normilized_bit_num2;
    assign rounding_mode       = main_q.rounding_mode;
    assign special_valid       = main_q.special_valid;
    assign special_result      = main_q.special_result;

endmodule

// File: tb/tb_fp_mul_operand_stage.sv
// tb/tb_fp_mul_operand_stage.sv - self-checking bench for fp_mul_operand_stage
module tb_fp_mul_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [1:0]  in_rm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        sign_num1, sign_num2;
    logic [7:0]  exp_num1, exp_num2;
    logic [22:0] mantissa_num1, mantissa_num2;
    logic        normilized_bit_num1, normilized_bit_num2;
    logic [1:0]  rounding_mode;
    logic        special_valid;
    logic [31:0] special_result;

    fp_mul_operand_stage dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_a                (in_a),
        .in_b                (in_b),
        .in_rm               (in_rm),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .sign_num1           (sign_num1),
        .sign_num2           (sign_num2),
        .exp_num1            (exp_num1),
        .exp_num2            (exp_num2),
        .mantissa_num1       (mantissa_num1),
        .mantissa_num2       (mantissa_num2),
        .normilized_bit_num1 (normilized_bit_num1),
        .normilized_bit_num2 (normilized_bit_num2),
        .rounding_mode       (rounding_mode),
        .special_valid       (special_valid),
        .special_result      (special_result)
    );

    always #5 clk = ~clk;

    wire [100:0] obs = {sign_num1, sign_num2, exp_num1, exp_num2, mantissa_num1, mantissa_num2,
                        normilized_bit_num1, normilized_bit_num2, rounding_mode,
                        special_valid, special_result};

    int           checks = 0;
    int           errors = 0;
    int           deliveries = 0;
    int           cyc = 0;
    bit           last_acc = 1'b0;
    logic [100:0] q[$];

    // Expected output entry for one operand pair, from the IEEE class rules.
    function automatic logic [100:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                               input logic [1:0] rm);
        int          ea, eb, prod_exp;
        bit          a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_norm, b_norm, s, sv;
        logic [31:0] sr;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        a_norm = (ea != 0) && (ea != 255);
        b_norm = (eb != 0) && (eb != 255);
        s = a[31] ^ b[31];
        prod_exp = ea + eb - 127;
        sv = 1'b1;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) sr = 32'h7FC00000;
        else if (a_inf || b_inf)                                       sr = {s, 31'h7F800000};
        else if (a_zero || b_zero)                                     sr = {s, 31'h0};
        else if (prod_exp < 0)                                         sr = {s, 31'h0};
        else if (prod_exp > 254)                                       sr = {s, 31'h7F800000};
        else begin
            sv = 1'b0;
            sr = 32'h0;
        end
        return {a[31], b[31], a[30:23], b[30:23], a[22:0], b[22:0], a_norm, b_norm, rm, sv, sr};
    endfunction

    function automatic logic [31:0] rand_op();
        logic        sg;
        logic [22:0] fr;
        sg = 1'($urandom);
        fr = 23'($urandom);
        case ($urandom_range(0, 7))
            0:       return {sg, 31'h0};
            1:       return {sg, 8'h00, fr | 23'd1};
            2:       return {sg, 8'hFF, 23'h0};
            3:       return {sg, 8'hFF, fr | 23'd1};
            4:       return {sg, 8'($urandom_range(1, 70)), fr};
            5:       return {sg, 8'($urandom_range(190, 254)), fr};
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [100:0] got, input logic [100:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: check occupancy and head entry at negedge, update the model, return at posedge+1.
    task automatic cycle();
        @(negedge clk);
        chk("out_valid", 101'(out_valid), 101'(q.size() != 0));
        chk("in_ready", 101'(in_ready), 101'(q.size() < 2));
        if (out_valid && q.size() > 0) chk("entry", obs, q[0]);
        last_acc = in_valid && in_ready;
        if (out_valid && out_ready && q.size() > 0) begin
            void'(q.pop_front());
            deliveries++;
        end
        if (last_acc) q.push_back(ref_model(in_a, in_b, in_rm));
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
        in_a = a;
        in_b = b;
        in_rm = rm;
        in_valid = 1'b1;
        last_acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (last_acc) break;
        end
        chk("send_accepted", 101'(last_acc), 101'(1));
        in_valid = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic exp_sv, input logic [31:0] exp_sr);
        out_ready = 1'b1;
        send(a, b, 2'b00);
        chk({tag, "_valid"}, 101'(out_valid), 101'(1));
        chk({tag, "_sv"}, 101'(special_valid), 101'(exp_sv));
        chk({tag, "_sr"}, 101'(special_result), 101'(exp_sr));
        cycle();
    endtask

    initial begin
        int base, c0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 101'(out_valid), 101'(0));
        chk("rst_in_ready", 101'(in_ready), 101'(1));
        chk("rst_special_valid", 101'(special_valid), 101'(0));
        chk("rst_data", obs, 101'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        send(32'h3F800000, 32'h40000000, 2'b00);
        chk("basic_valid", 101'(out_valid), 101'(1));
        chk("basic_sv", 101'(special_valid), 101'(0));
        chk("basic_exp1", 101'(exp_num1), 101'(127));
        chk("basic_exp2", 101'(exp_num2), 101'(128));
        chk("basic_hidden", 101'({normilized_bit_num1, normilized_bit_num2}), 101'(2'b11));
        cycle();

        directed("inf_x_zero", 32'h7F800000, 32'h00000000, 1'b1, 32'h7FC00000);
        directed("nan_x_one",  32'h7F800001, 32'h3F800000, 1'b1, 32'h7FC00000);
        directed("ninf_x_one", 32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000);
        directed("sub_x_one",  32'h80000001, 32'h3F800000, 1'b1, 32'h80000000);
        directed("sum_126",    32'h1F800000, 32'h1F800000, 1'b1, 32'h00000000);
        directed("sum_508",    32'h7F000000, 32'h7F000000, 1'b1, 32'h7F800000);
        directed("sum_127",    32'h20000000, 32'h1F800000, 1'b0, 32'h00000000);

        // Backpressure: two entries fill the buffer, the third is held off.
        out_ready = 1'b0;
        send(rand_op(), rand_op(), 2'b01);
        send(rand_op(), rand_op(), 2'b10);
        chk("bp_in_ready_low", 101'(in_ready), 101'(0));
        in_a = rand_op();
        in_b = rand_op();
        in_rm = 2'b11;
        in_valid = 1'b1;
        repeat (3) cycle();
        chk("bp_no_accept", 101'(last_acc), 101'(0));
        base = deliveries;
        out_ready = 1'b1;
        send(in_a, in_b, in_rm);
        send(rand_op(), rand_op(), 2'b00);
        cycle();
        chk("bp_delivered_4", 101'(deliveries - base), 101'(4));
        chk("bp_drained", 101'(q.size()), 101'(0));

        // Full throughput.
        base = deliveries;
        c0 = cyc;
        for (int i = 0; i < 16; i++) send(rand_op(), rand_op(), 2'($urandom));
        cycle();
        chk("tp_cycles", 101'(cyc - c0), 101'(17));
        chk("tp_delivered_16", 101'(deliveries - base), 101'(16));

        // Reset with both entries occupied.
        out_ready = 1'b0;
        send(rand_op(), rand_op(), 2'b01);
        send(rand_op(), rand_op(), 2'b10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 101'(out_valid), 101'(0));
        chk("mid_rst_in_ready", 101'(in_ready), 101'(1));
        chk("mid_rst_data", obs, 101'(0));
        q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (4) cycle();

        // Randomized traffic with random backpressure; producer holds until accepted.
        last_acc = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_a = rand_op();
                in_b = rand_op();
                in_rm = 2'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();
        chk("final_drained", 101'(q.size()), 101'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
